fft_bitrev_reorder_ctrl: RTL and testbench



---
 rtl/fft_reorder_pkg.sv | 26 ++
 rtl/reorder_out_fifo.sv | 65 ++++++
 rtl/fft_bitrev_reorder_ctrl.sv | 152 +++++++++++++++
 tb/tb_fft_bitrev_reorder_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_reorder_pkg.sv
// Shared types and helpers for the FFT bit-reversal reorder controller.
//   bank_state_e : life cycle of one ping-pong bank
//   MaxLogN      : widest frame index handled by bitrev()
//   bitrev()     : reverses the low w bits of v, upper bits return 0
package fft_reorder_pkg;

    localparam int MaxLogN = 12;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_e;

    function automatic logic [MaxLogN-1:0] bitrev(input logic [MaxLogN-1:0] v,
                                                  input int unsigned w);
        logic [MaxLogN-1:0] r;
        for (int i = 0; i < MaxLogN; i++) begin
            r[i] = v[MaxLogN-1-i];
        end
        // Full-width reversal lands the w useful bits at the top; move them down.
        return r >> (MaxLogN - w);
    endfunction

endpackage

// File: rtl/reorder_out_fifo.sv
// Small synchronous output FIFO for the reorder controller.
// Head entry is always data_q[0], so rdata_o comes straight from a register.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   push_i/wdata_i: write one entry (never while full)
//   pop_i         : remove head entry (only while valid_o)
//   valid_o       : FIFO not empty
//   rdata_o       : head entry
//   count_o       : number of stored entries
module reorder_out_fifo #(
    parameter  int Depth = 2,
    parameter  int Width = 8,
    localparam int CntW  = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [Width-1:0] rdata_o,
    output logic [CntW-1:0]  count_o
);

    logic [Width-1:0] data_q [Depth];
    logic [Width-1:0] data_d [Depth];
    logic [CntW-1:0]  count_q, count_d;

    always_comb begin
        data_d  = data_q;
        count_d = count_q;
        if (pop_i) begin
            for (int i = 0; i < Depth - 1; i++) begin
                data_d[i] = data_q[i+1];
            end
            count_d = count_d - CntW'(1);
        end
        // Slot index uses the post-pop count so push and pop can coincide.
        if (push_i) begin
            for (int i = 0; i < Depth; i++) begin
                if (count_d == CntW'(i)) data_d[i] = wdata_i;
            end
            count_d = count_d + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) data_q[i] <= '0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    always @(posedge clk_i) begin
        if (rst_ni && push_i) assert (count_q < CntW'(Depth));
    end

    assign valid_o = (count_q != '0);
    assign rdata_o = data_q[0];
    assign count_o = count_q;

endmodule

// File: rtl/fft_bitrev_reorder_ctrl.sv
// Converts the bit-reversed FFT output stream into natural order using an
// external dual-port sram as a two-bank ping-pong buffer (address MSB = bank).
// Port 0 writes incoming samples sequentially, port 1 reads in bit-reversed
// address order; a small FIFO absorbs the sram read latency.
// Ports:
//   clk_i, rst_ni                     : clock, async active-low reset
//   in_valid_i/in_ready_o/in_data_i   : bit-reversed input stream
//   out_valid_o/out_ready_i/out_data_o/out_last_o : natural-order output stream
//   mem_cs_o/mem_wen_o/mem_addr_o/mem_wdata_o/mem_rdata_i : sram ports [0]=wr [1]=rd
//
// Per-bank state:
//   state    | meaning
//   EMPTY    | no unread data, writer may start a frame here
//   FILLING  | writer has placed part of a frame
//   FULL     | complete frame stored, no read issued yet
//   DRAINING | reads in progress; freed when the last read is issued
module fft_bitrev_reorder_ctrl
    import fft_reorder_pkg::*;
#(
    parameter  int LogN       = 4,
    parameter  int DataWidth  = 32,
    parameter  int MemLatency = 1,
    localparam int FifoDepth  = MemLatency + 1,
    localparam int AddrWidth  = LogN + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [DataWidth-1:0]      in_data_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [DataWidth-1:0]      out_data_o,
    output logic                      out_last_o,
    output logic [1:0]                mem_cs_o,
    output logic [1:0]                mem_wen_o,
    output logic [1:0][AddrWidth-1:0] mem_addr_o,
    output logic [1:0][DataWidth-1:0] mem_wdata_o,
    input  logic [1:0][DataWidth-1:0] mem_rdata_i
);

    localparam int CntW = $clog2(FifoDepth + 1);
    localparam int OccW = $clog2(FifoDepth + MemLatency + 1) + 1;

    bank_state_e           bank_q [2];
    bank_state_e           bank_d [2];
    logic                  wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [LogN-1:0]       wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic [MemLatency-1:0] vld_q, vld_d, last_q, last_d;

    logic                  wr_accept, rd_issue, wr_last, rd_last;
    logic [MaxLogN-1:0]    rd_rev;
    logic [OccW-1:0]       inflight, occ;
    logic [CntW-1:0]       fifo_cnt;
    logic                  fifo_pop;
    logic [DataWidth:0]    fifo_rdata;
    logic                  unused_inputs;

    assign in_ready_o = (bank_q[wr_bank_q] == EMPTY) || (bank_q[wr_bank_q] == FILLING);
    assign wr_accept  = in_valid_i && in_ready_o;
    assign wr_last    = &wr_cnt_q;
    assign rd_last    = &rd_cnt_q;
    assign rd_rev     = bitrev(MaxLogN'(rd_cnt_q), LogN);
    assign fifo_pop   = out_valid_o && out_ready_i;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < MemLatency; i++) begin
            inflight = inflight + OccW'(vld_q[i]);
        end
    end

    // Space check counts reads still in the sram pipeline and credits this
    // cycle's pop, which keeps the stream bubble-free at full rate.
    assign occ      = OccW'(fifo_cnt) + inflight - OccW'(fifo_pop);
    assign rd_issue = ((bank_q[rd_bank_q] == FULL) || (bank_q[rd_bank_q] == DRAINING))
                      && (occ < OccW'(FifoDepth));

    always_comb begin
        bank_d    = bank_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        // Writer and reader always own different banks, so both updates apply.
        if (wr_accept) begin
            bank_d[wr_bank_q] = wr_last ? FULL : FILLING;
            wr_cnt_d          = wr_cnt_q + LogN'(1);
            if (wr_last) wr_bank_d = ~wr_bank_q;
        end
        if (rd_issue) begin
            bank_d[rd_bank_q] = rd_last ? EMPTY : DRAINING;
            rd_cnt_d          = rd_cnt_q + LogN'(1);
            if (rd_last) rd_bank_d = ~rd_bank_q;
        end
        vld_d     = vld_q;
        last_d    = last_q;
        vld_d[0]  = rd_issue;
        last_d[0] = rd_issue && rd_last;
        for (int i = 1; i < MemLatency; i++) begin
            vld_d[i]  = vld_q[i-1];
            last_d[i] = last_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 2; i++) bank_q[i] <= EMPTY;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            vld_q     <= '0;
            last_q    <= '0;
        end else begin
            bank_q    <= bank_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            vld_q     <= vld_d;
            last_q    <= last_d;
        end
    end

    reorder_out_fifo #(
        .Depth (FifoDepth),
        .Width (DataWidth + 1)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (vld_q[MemLatency-1]),
        .wdata_i ({last_q[MemLatency-1], mem_rdata_i[1]}),
        .pop_i   (fifo_pop),
        .valid_o (out_valid_o),
        .rdata_o (fifo_rdata),
        .count_o (fifo_cnt)
    );

    assign out_last_o     = fifo_rdata[DataWidth];
    assign out_data_o     = fifo_rdata[DataWidth-1:0];

    assign mem_cs_o       = {rd_issue, wr_accept};
    assign mem_wen_o      = 2'b01;
    assign mem_addr_o[0]  = {wr_bank_q, wr_cnt_q};
    assign mem_addr_o[1]  = {rd_bank_q, rd_rev[LogN-1:0]};
    assign mem_wdata_o[0] = in_data_i;
    assign mem_wdata_o[1] = '0;

    assign unused_inputs  = ^{mem_rdata_i[0], rd_rev};

endmodule

// File: tb/tb_fft_bitrev_reorder_ctrl.sv
module tb_fft_bitrev_reorder_ctrl;

    localparam int LogN = 4;
    localparam int N    = 16;
    localparam int DW   = 32;
    localparam int AW   = LogN + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic                 in_valid [2], in_ready [2], out_valid [2], out_ready [2], out_last [2];
    logic [DW-1:0]        in_data [2], out_data [2];
    logic [1:0]           mem_cs [2], mem_wen [2];
    logic [1:0][AW-1:0]   mem_addr [2];
    logic [1:0][DW-1:0]   mem_wdata [2], mem_rdata [2];

    // Instance 0: MemLatency=1, instance 1: MemLatency=3. Each has its own sram model.
    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int Lat = (g == 0) ? 1 : 3;
        fft_bitrev_reorder_ctrl #(.LogN(LogN), .DataWidth(DW), .MemLatency(Lat)) dut (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .in_valid_i  (in_valid[g]),
            .in_ready_o  (in_ready[g]),
            .in_data_i   (in_data[g]),
            .out_valid_o (out_valid[g]),
            .out_ready_i (out_ready[g]),
            .out_data_o  (out_data[g]),
            .out_last_o  (out_last[g]),
            .mem_cs_o    (mem_cs[g]),
            .mem_wen_o   (mem_wen[g]),
            .mem_addr_o  (mem_addr[g]),
            .mem_wdata_o (mem_wdata[g]),
            .mem_rdata_i (mem_rdata[g])
        );
        logic [DW-1:0] sram [2*N];
        logic [DW-1:0] pipe [Lat];
        always @(posedge clk) begin
            if (mem_cs[g][0] && mem_wen[g][0]) sram[mem_addr[g][0]] <= mem_wdata[g][0];
            if (mem_cs[g][1]) pipe[0] <= sram[mem_addr[g][1]];
            for (int i = 1; i < Lat; i++) pipe[i] <= pipe[i-1];
        end
        assign mem_rdata[g] = {pipe[Lat-1], {DW{1'b0}}};
    end

    typedef struct {
        logic [DW-1:0] din;
        logic [DW-1:0] dout;
        logic          last;
    } vec_t;
    vec_t tbl [N];

    logic [DW:0]   exp_q0 [$];
    logic [DW:0]   exp_q1 [$];
    logic [DW:0]   cap_v [$];
    int            cap_c [$];
    logic [DW-1:0] fbuf [2][N];
    int            widx [2], seq [2], out_cnt [2], acc_cyc [2], stalls [2];
    int            n_checks = 0, n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int brev4(input int v);
        logic [3:0] r;
        r = {v[0], v[1], v[2], v[3]};
        return int'(r);
    endfunction

    // Scoreboard: a completed input frame pushes its natural-order expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int s = 0; s < 2; s++) begin
                if (in_valid[s] && in_ready[s]) begin
                    fbuf[s][widx[s]] = in_data[s];
                    if (widx[s] == N - 1) begin
                        for (int p = 0; p < N; p++) begin
                            if (s == 0) exp_q0.push_back({p == N - 1, fbuf[s][brev4(p)]});
                            else        exp_q1.push_back({p == N - 1, fbuf[s][brev4(p)]});
                        end
                        widx[s]    = 0;
                        acc_cyc[s] = cyc;
                    end else begin
                        widx[s]++;
                    end
                end
                if (out_valid[s] && out_ready[s]) begin
                    logic [DW:0] e;
                    logic        have;
                    have = (s == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
                    out_cnt[s]++;
                    if (s == 0) begin
                        cap_v.push_back({out_last[s], out_data[s]});
                        cap_c.push_back(cyc);
                    end
                    if (!have) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL sb_unexpected inst%0d: got %0h with nothing expected", s, out_data[s]);
                    end else begin
                        e = (s == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        chk($sformatf("sb_data%0d", s), 64'(out_data[s]), 64'(e[DW-1:0]));
                        chk($sformatf("sb_last%0d", s), 64'(out_last[s]), 64'(e[DW]));
                    end
                end
            end
        end
    end

    task automatic send(input int s, input int n, input int budget, input bit from_tbl,
                        output int sent);
        int waited;
        sent   = 0;
        waited = 0;
        while (sent < n && waited < budget) begin
            in_valid[s] = 1'b1;
            in_data[s]  = from_tbl ? tbl[sent].din : DW'(seq[s]);
            @(negedge clk);
            if (in_ready[s]) begin
                sent++;
                seq[s]++;
            end else begin
                stalls[s]++;
            end
            @(posedge clk);
            #1;
            waited++;
        end
        in_valid[s] = 1'b0;
    endtask

    task automatic wait_outputs(input int s, input int target, input int budget);
        int k;
        k = 0;
        while (out_cnt[s] < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk($sformatf("out_count%0d", s), 64'(out_cnt[s]), 64'(target));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            in_valid[s] = 1'b0;
            widx[s]     = 0;
            seq[s]      = 0;
            out_cnt[s]  = 0;
            stalls[s]   = 0;
        end
        exp_q0.delete();
        exp_q1.delete();
        cap_v.delete();
        cap_c.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic tbl_check(input int base, input int dofs);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("order_data[%0d]", base + i), 64'(cap_v[base+i][DW-1:0]),
                64'(tbl[i].dout + DW'(dofs)));
            chk($sformatf("order_last[%0d]", base + i), 64'(cap_v[base+i][DW]), 64'(tbl[i].last));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int sent;
        bit done;
        int ord [N] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
        for (int i = 0; i < N; i++) begin
            tbl[i].din  = DW'(i);
            tbl[i].dout = DW'(ord[i]);
            tbl[i].last = (i == N - 1);
        end
        for (int s = 0; s < 2; s++) begin
            in_valid[s]  = 1'b0;
            in_data[s]   = '0;
            out_ready[s] = 1'b0;
        end
        rst_n = 1'b0;

        // Reset values
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_in_ready", 64'(in_ready[s]), 64'd1);
            chk("rst_out_valid", 64'(out_valid[s]), 64'd0);
            chk("rst_out_last", 64'(out_last[s]), 64'd0);
            chk("rst_out_data", 64'(out_data[s]), 64'd0);
            chk("rst_mem_cs", 64'(mem_cs[s]), 64'd0);
            chk("rst_mem_wen", 64'(mem_wen[s]), 64'd1);
        end
        do_reset();

        // Single frame: ordering, last flag, latency
        out_ready[0] = 1'b1;
        send(0, N, 100, 1'b1, sent);
        chk("t1_sent", 64'(sent), 64'(N));
        wait_outputs(0, N, 60);
        tbl_check(0, 0);
        chk("t1_latency", 64'(cap_c[0] - acc_cyc[0]), 64'd3);

        // Three back-to-back frames, no stalls, no output bubbles
        do_reset();
        out_ready[0] = 1'b1;
        send(0, 3 * N, 200, 1'b0, sent);
        chk("t2_sent", 64'(sent), 64'(3 * N));
        chk("t2_in_stalls", 64'(stalls[0]), 64'd0);
        wait_outputs(0, 3 * N, 100);
        chk("t2_no_gaps", 64'(cap_c[3*N-1] - cap_c[0]), 64'(3 * N - 1));
        for (int f = 0; f < 3; f++) tbl_check(f * N, f * N);

        // Full backpressure: both banks fill, then drain
        do_reset();
        out_ready[0] = 1'b0;
        send(0, 3 * N, 60, 1'b0, sent);
        chk("t3_accepted", 64'(sent), 64'(2 * N));
        @(negedge clk);
        chk("t3_in_ready_low", 64'(in_ready[0]), 64'd0);
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
        wait_outputs(0, 2 * N, 120);
        @(negedge clk);
        chk("t3_in_ready_back", 64'(in_ready[0]), 64'd1);
        chk("t3_sb_empty", 64'(exp_q0.size()), 64'd0);
        tbl_check(0, 0);
        tbl_check(N, N);

        // MemLatency=3 with random backpressure over 10 frames
        do_reset();
        done = 1'b0;
        fork
            begin
                send(1, 10 * N, 3000, 1'b0, sent);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready[1] = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready[1] = 1'b1;
        chk("t4_sent", 64'(sent), 64'(10 * N));
        wait_outputs(1, 10 * N, 200);
        chk("t4_sb_empty", 64'(exp_q1.size()), 64'd0);

        // Reset after 7 writes of frame 0
        do_reset();
        out_ready[0] = 1'b1;
        send(0, 7, 20, 1'b0, sent);
        do_reset();
        @(negedge clk);
        chk("t5_out_valid", 64'(out_valid[0]), 64'd0);
        chk("t5_in_ready", 64'(in_ready[0]), 64'd1);
        chk("t5_mem_cs", 64'(mem_cs[0]), 64'd0);
        @(posedge clk);
        #1;
        send(0, N, 100, 1'b1, sent);
        wait_outputs(0, N, 60);
        tbl_check(0, 0);

        // Reset while draining with data held in the FIFO
        do_reset();
        out_ready[0] = 1'b0;
        send(0, N, 100, 1'b0, sent);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("t6_fifo_loaded", 64'(out_valid[0]), 64'd1);
        @(posedge clk);
        #1;
        do_reset();
        out_ready[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t6_no_stale_valid", 64'(out_valid[0]), 64'd0);
        end
        @(posedge clk);
        #1;
        send(0, N, 100, 1'b1, sent);
        wait_outputs(0, N, 60);
        tbl_check(0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
